// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver.
// Synchronises the PS/2 clock/data pair, deserialises 11-bit frames and checks
// their start, parity and stop bits. E0 (extended) and F0 (release) prefixes are
// folded into 10-bit key events {pressed, extended, code}, which are buffered in
// a small FIFO with a registered head.
// Optional feature: define PS2_TIMEOUT_EN to abort a partial frame after
// TIMEOUT_CYC clk_sys cycles without a falling PS/2 clock edge.
module ps2_kbd_rx #(
    parameter int FIFO_AW = 3
`ifdef PS2_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 20000
`endif
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [9:0] ev_data,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       overflow,
    output logic       frame_err,
    output logic [7:0] err_cnt,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    localparam int DEPTH = 1 << FIFO_AW;

    // Input synchronisers and falling-edge detector
    logic r_clk_m, r_clk_s, r_clk_prev;
    logic r_dat_m, r_dat_s;
    logic w_fall;

    // Frame FSM
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shreg;
    logic       r_par;
    logic       r_byte_rdy;
    logic       r_frame_err;
    logic       r_abort;
    logic [7:0] r_err_cnt;

    // Prefix decoder
    logic       r_ext;
    logic       r_rel;
    logic       r_push;
    logic [9:0] r_push_data;

    // Event FIFO
    logic [9:0]       r_mem [DEPTH];
    logic [FIFO_AW:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0] w_wr_nxt, w_rd_nxt;
    logic             w_full, w_pop, w_wr_en;
    logic [9:0]       w_head_nxt;
    logic [9:0]       r_ev_data;
    logic             r_ev_valid;
    logic             r_overflow;

`ifdef PS2_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_timeout;
`endif

    // Two-flop synchronisers (preset high, matching the idle bus) plus edge history
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clk_m    <= 1'b1;
            r_clk_s    <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_m    <= 1'b1;
            r_dat_s    <= 1'b1;
        end else begin
            r_clk_m    <= ps2_clk;
            r_clk_s    <= r_clk_m;
            r_clk_prev <= r_clk_s;
            r_dat_m    <= ps2_data;
            r_dat_s    <= r_dat_m;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s;

    // Frame FSM: advances on each synchronised falling PS/2 clock edge
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shreg     <= 8'd0;
            r_par       <= 1'b0;
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
            r_abort     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
            r_abort     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            r_timeout   <= 1'b0;
`endif
            if (w_fall) begin
`ifdef PS2_TIMEOUT_EN
                r_to_cnt <= '0;
`endif
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s) begin
                            r_state   <= S_DATA;
                            r_bit_cnt <= 3'd0;
                        end else begin
                            // Start bit of 1 is a spurious start
                            r_frame_err <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        r_shreg   <= {r_dat_s, r_shreg[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                    S_PARITY: begin
                        r_par   <= r_dat_s;
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        if (r_dat_s && (^{r_shreg, r_par})) begin
                            r_byte_rdy <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_abort     <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
`ifdef PS2_TIMEOUT_EN
            else if (r_state != S_IDLE) begin
                if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                    r_state     <= S_IDLE;
                    r_to_cnt    <= '0;
                    r_timeout   <= 1'b1;
                    r_frame_err <= 1'b1;
                    r_abort     <= 1'b1;
                end else begin
                    r_to_cnt <= r_to_cnt + TW'(1);
                end
            end else begin
                r_to_cnt <= '0;
            end
`endif
        end
    end

`ifdef PS2_TIMEOUT_EN
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    // Saturating error counter
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_err_cnt <= 8'd0;
        end else if (r_frame_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    // Prefix decoder: E0/F0 set flags, any other byte becomes an event
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ext       <= 1'b0;
            r_rel       <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 10'd0;
        end else begin
            r_push <= 1'b0;
            if (r_byte_rdy) begin
                if (r_shreg == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_shreg == 8'hF0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_push      <= 1'b1;
                    r_push_data <= {~r_rel, r_ext, r_shreg};
                    r_ext       <= 1'b0;
                    r_rel       <= 1'b0;
                end
            end else if (r_abort) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else begin
                r_ext <= r_ext;
                r_rel <= r_rel;
            end
        end
    end

    // FIFO next-state: pointer updates and the head value for the next cycle
    always_comb begin
        w_pop    = r_ev_valid & ev_ready;
        w_full   = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                   (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
        w_wr_en  = r_push & (~w_full | w_pop);
        w_wr_nxt = r_wr_ptr;
        w_rd_nxt = r_rd_ptr;
        if (w_wr_en) begin
            w_wr_nxt = r_wr_ptr + (FIFO_AW+1)'(1);
        end else begin
            w_wr_nxt = r_wr_ptr;
        end
        if (w_pop) begin
            w_rd_nxt = r_rd_ptr + (FIFO_AW+1)'(1);
        end else begin
            w_rd_nxt = r_rd_ptr;
        end
        // The slot being written this cycle becomes the head if the read pointer lands on it
        if (w_wr_en && (w_rd_nxt[FIFO_AW-1:0] == r_wr_ptr[FIFO_AW-1:0])) begin
            w_head_nxt = r_push_data;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt[FIFO_AW-1:0]];
        end
    end

    // FIFO storage array
    always_ff @(posedge clk_sys) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= r_push_data;
        end
    end

    // FIFO pointers, registered head and overflow pulse
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ev_data  <= 10'd0;
            r_ev_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_nxt;
            r_rd_ptr   <= w_rd_nxt;
            r_ev_valid <= (w_wr_nxt != w_rd_nxt);
            r_ev_data  <= w_head_nxt;
            r_overflow <= r_push & w_full & ~w_pop;
        end
    end

    assign ev_data   = r_ev_data;
    assign ev_valid  = r_ev_valid;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Scoreboard testbench for ps2_kbd_rx: PS/2 frames are driven on the pins,
// expected key events are queued as stimulus is issued, and a monitor pops
// and compares whenever the DUT hands over an event.
module tb_ps2_kbd_rx;

    localparam int HALF = 8;   // clk_sys cycles per PS/2 clock phase

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [9:0] ev_data;
    logic       ev_valid;
    logic       ev_ready;
    logic       overflow;
    logic       frame_err;
    logic [7:0] err_cnt;
    logic       timeout;

    logic [9:0] exp_q[$];
    int n_chk   = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    int ovf_cnt = 0;
    int ferr_cnt = 0;
    int to_cnt  = 0;
    int both_cnt = 0;

    ps2_kbd_rx #(
        .FIFO_AW(3)
`ifdef PS2_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ev_data  (ev_data),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .overflow (overflow),
        .frame_err(frame_err),
        .err_cnt  (err_cnt),
        .timeout  (timeout)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every handed-over event against the scoreboard head
    initial begin
        forever begin
            @(negedge clk_sys);
            #1;
            if (!reset) begin
                if (ev_valid && ev_ready) begin
                    n_pop++;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_event: got 0x%0h, expected none", ev_data);
                    end else begin
                        logic [9:0] e;
                        e = exp_q.pop_front();
                        if (ev_data != e) begin
                            n_fail++;
                            $display("FAIL event: got 0x%0h, expected 0x%0h", ev_data, e);
                        end
                    end
                end
                if (overflow) ovf_cnt++;
                if (frame_err) ferr_cnt++;
                if (timeout) to_cnt++;
                if (frame_err && timeout) both_cnt++;
            end
        end
    end

    // One PS/2 bit: data set while clock high, then a low and a high phase.
    // With pulse set, ev_ready is raised for exactly the cycle in which the
    // event decoded from this falling edge is pushed into the FIFO.
    task automatic ps2_bit(input logic b, input bit pulse);
        @(negedge clk_sys);
        ps2_data = b;
        repeat (HALF) @(negedge clk_sys);
        ps2_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            @(negedge clk_sys);
            if (pulse && i == 4) ev_ready = 1'b1;
            if (pulse && i == 5) ev_ready = 1'b0;
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pulse);
        logic p;
        p = ~(^b) ^ bad_par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
        ps2_bit(p, 1'b0);
        ps2_bit(1'b1, pulse);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk_sys);
    endtask

    task automatic wait_drained(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_sys);
            #2;
            if (exp_q.size() == 0 && !ev_valid) done = 1'b1;
        end
        check({name, "_drained"}, int'(done), 1);
    endtask

    initial begin
        int base_pop;
        int base_err;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        ev_ready = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1;
        check("rst_ev_valid", int'(ev_valid), 0);
        check("rst_ev_data", int'(ev_data), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_timeout", int'(timeout), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        repeat (4) @(negedge clk_sys);

        // Plain make code
        exp_q.push_back(10'h21C);
        send_frame(8'h1C, 1'b0, 1'b0);
        wait_drained("make_1c");
        check("make_1c_ferr", ferr_cnt, 0);

        // Release and extended release
        exp_q.push_back(10'h01C);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        wait_drained("brk_1c");
        exp_q.push_back(10'h175);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        wait_drained("ext_brk_75");

        // Prefixes alone push nothing, but stay pending for the next code
        base_pop = n_pop;
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        repeat (20) @(negedge clk_sys);
        check("prefix_no_push", n_pop - base_pop, 0);
        exp_q.push_back(10'h11C);
        send_frame(8'h1C, 1'b0, 1'b0);
        wait_drained("prefix_then_1c");

        // Parity error drops the byte and clears a pending release prefix
        base_pop = n_pop;
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b1, 1'b0);
        repeat (5) @(negedge clk_sys);
        #1;
        check("par_err_pulses", ferr_cnt, 1);
        check("par_err_cnt", int'(err_cnt), 1);
        check("par_err_no_event", n_pop - base_pop, 0);
        exp_q.push_back(10'h375);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        wait_drained("after_err_e0_75");

        // Spurious start (data high on a falling clock in IDLE)
        ps2_bit(1'b1, 1'b0);
        repeat (10) @(negedge clk_sys);
        #1;
        check("spurious_pulses", ferr_cnt, 2);
        check("spurious_err_cnt", int'(err_cnt), 2);

        // Fill past capacity with no consumer
        ev_ready = 1'b0;
        base_pop = n_pop;
        for (int k = 1; k <= 9; k++) begin
            logic [7:0] c;
            c = 8'(k);
            if (k <= 8) exp_q.push_back({2'b10, c});
            send_frame(c, 1'b0, 1'b0);
        end
        #1;
        check("ovf_pulses", ovf_cnt, 1);
        check("ovf_full_valid", int'(ev_valid), 1);
        check("ovf_head", int'(ev_data), 10'h201);
        ev_ready = 1'b1;
        wait_drained("ovf_drain");
        check("ovf_drain_pops", n_pop - base_pop, 8);

        // Push and pop in the same cycle while full: nothing dropped
        ev_ready = 1'b0;
        base_pop = n_pop;
        for (int k = 8'h11; k <= 8'h18; k++) begin
            logic [7:0] c;
            c = 8'(k);
            exp_q.push_back({2'b10, c});
            send_frame(c, 1'b0, 1'b0);
        end
        exp_q.push_back(10'h219);
        send_frame(8'h19, 1'b0, 1'b1);
        #1;
        check("full_pushpop_no_ovf", ovf_cnt, 1);
        check("full_pushpop_one_pop", n_pop - base_pop, 1);
        check("full_pushpop_head", int'(ev_data), 10'h212);
        ev_ready = 1'b1;
        wait_drained("full_pushpop_drain");
        check("full_pushpop_pops", n_pop - base_pop, 9);

        // Reset in the middle of a frame, then a clean frame
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (3) @(negedge clk_sys);
        #1;
        check("midrst_err_cnt", int'(err_cnt), 0);
        check("midrst_ev_valid", int'(ev_valid), 0);
        @(negedge clk_sys);
        reset = 1'b0;
        base_err = ferr_cnt;
        exp_q.push_back(10'h25A);
        send_frame(8'h5A, 1'b0, 1'b0);
        wait_drained("midrst_5a");
        check("midrst_no_err", ferr_cnt - base_err, 0);
        check("midrst_err_cnt_after", int'(err_cnt), 0);

`ifdef PS2_TIMEOUT_EN
        // Partial frame aborted by the timeout
        base_err = ferr_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        repeat (150) @(negedge clk_sys);
        #1;
        check("to_pulses", to_cnt, 1);
        check("to_ferr", ferr_cnt - base_err, 1);
        check("to_coincident", both_cnt, 1);
        check("to_err_cnt", int'(err_cnt), 1);
        exp_q.push_back(10'h21C);
        send_frame(8'h1C, 1'b0, 1'b0);
        wait_drained("to_then_1c");
`else
        check("no_timeout", to_cnt, 0);
`endif

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
- Receiver stage directly downstream of the HPS I/O block's PS/2 keyboard transmitter.
- Consumes ps2_kbd_clk / ps2_kbd_data, which idle high and change data on rising clock edges.
- Deserialises 11-bit frames, checks start, parity and stop bits, and folds E0/F0 prefixes into key events.
- Buffers events in a FIFO for the core's keyboard matrix logic.

Parameters:
FIFO_AW, 3, log2 of event FIFO depth (depth = 8)
TIMEOUT_CYC, 20000, clk_sys cycles without a falling ps2 edge before a partial frame is aborted (PS2_TIMEOUT_EN only)

Ports:
clk_sys  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
ps2_clk  input  1  PS/2 clock from hps_io; asynchronous to clk_sys, idle high
ps2_data  input  1  PS/2 data from hps_io
ev_data  output  10  {pressed, extended, code[7:0]} at FIFO head
ev_valid  output  1  FIFO not empty
ev_ready  input  1  consumer pops the head when ev_valid & ev_ready
overflow  output  1  one-cycle pulse when an event is dropped because the FIFO is full
frame_err  output  1  one-cycle pulse on a start, parity or stop error, or a timeout
err_cnt  output  8  saturating count of frame_err pulses
timeout  output  1  one-cycle pulse on frame abort (always 0 without PS2_TIMEOUT_EN)

Behaviour:
- Reset (async, active-high):
  - All outputs 0; FIFO empty.
  - Sync flops preset to 1.
  - FSM goes to IDLE; prefix flags ext/rel cleared.
  - Reset mid-frame discards the partial frame.
- Input sync:
  - ps2_clk and ps2_data each pass through 2-flop synchronisers.
  - fall = prev_clk & ~clk_s. Data is sampled on the cycle fall is high.
  - Latency from pin edge to sample: 3 clk_sys cycles.
- FSM, advancing only on fall:
  - IDLE: data=0 → DATA with bit_cnt=0. Data=1 → stay in IDLE, pulse frame_err (spurious start).
  - DATA: shift in LSB first (shreg <= {d, shreg[7:1]}). bit_cnt 0..7; after bit 7 → PARITY.
  - PARITY: latch p → STOP.
  - STOP:
    - Valid frame: stop=1 and ^{shreg,p}==1 (odd parity). Assert byte_rdy for one cycle, then → IDLE.
    - Invalid frame: byte discarded, frame_err pulse, ext/rel cleared, → IDLE.
- Decoder, on byte_rdy:
  - Byte 0xE0: ext<=1, nothing pushed.
  - Byte 0xF0: rel<=1, nothing pushed.
  - Any other byte: push {~rel, ext, byte}, then clear ext and rel.
  - Push occurs the cycle after byte_rdy.
- FIFO:
  - Registered output, no fall-through; ev_data/ev_valid update the cycle after a push into an empty FIFO.
  - Pointers are FIFO_AW+1 bits, so full and empty are distinguishable across wrap.
  - Push while full without a pop: event dropped, overflow pulses, pointers unchanged.
  - Push and pop in the same cycle while full: both happen, nothing dropped.
  - Push and pop in the same cycle while holding one entry: ev_valid stays 1 and ev_data shows the new event.
  - Pop while empty: ignored.
- err_cnt increments on each frame_err and saturates at 0xFF.
- frame_err and overflow may both pulse in the same cycle.

Optional Feature:
Macro PS2_TIMEOUT_EN.
- Defined:
  - A counter runs while the FSM is not IDLE; it clears on every fall.
  - At TIMEOUT_CYC the FSM → IDLE and the partial byte is discarded.
  - ext/rel are cleared; timeout and frame_err pulse together.
  - The counter is sized $clog2(TIMEOUT_CYC+1).
- Undefined:
  - No counter is built; timeout is tied to 0.
  - A truncated frame completes with the next frame's bits.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) → one event 10'h21C (pressed=1, ext=0), frame_err=0.
- Bytes F0,1C → one event 10'h01C. Bytes E0,F0,75 → one event 10'h175. Prefix bytes alone push nothing.
- 0x1C sent with parity bit 1 → no event, one frame_err pulse, err_cnt=1. A following E0,75 still yields 10'h375.
- ev_ready=0 while 9 make codes 0x01..0x09 are sent → FIFO holds 01..08 and overflow pulses once on 0x09. Then ev_ready=1 drains 10'h201..10'h208 in order, ev_valid falls after the 8th pop. A further push in the same cycle as a pop while full is not dropped.
- Reset asserted after 4 data bits of a frame, then a clean 0x5A frame → single event 10'h25A with no error.
- With PS2_TIMEOUT_EN and TIMEOUT_CYC=100: send start + 3 bits, hold clock high 150 cycles → timeout and frame_err pulse at cycle 100 after the last fall. A following 0x1C frame decodes to 10'h21C.
